kinematics_multi: RTL and testbench



---
 rtl/kinematics_pkg.sv | 48 ++++
 rtl/kinematics_multi_lut.sv | 21 ++
 rtl/kinematics_multi.sv | 245 ++++++++++++++++++++++++
 tb/tb_kinematics_multi.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/kinematics_pkg.sv
// Shared types and helpers for the multi-object kinematics block.
// Holds the FSM encoding, the quarter-wave sine table and the wall/velocity helpers.
package kinematics_pkg;

    typedef enum logic [2:0] {IDLE, MOVE, TRIG, MUL, STORE} state_t;

    // {bounce, pos[31:0]}; kept as a flat vector so callers can slice it by cast
    typedef logic [32:0] refl_t;

    // sin((j+0.5)*pi/64) in parts per million
    function automatic int unsigned sin_ppm(input int unsigned j);
        case (j)
            0:  return 24541;   1:  return 73565;   2:  return 122411;  3:  return 170962;
            4:  return 219101;  5:  return 266713;  6:  return 313682;  7:  return 359895;
            8:  return 405241;  9:  return 449611;  10: return 492898;  11: return 534998;
            12: return 575808;  13: return 615232;  14: return 653173;  15: return 689541;
            16: return 724247;  17: return 757209;  18: return 788346;  19: return 817585;
            20: return 844854;  21: return 870087;  22: return 893224;  23: return 914210;
            24: return 932993;  25: return 949528;  26: return 963776;  27: return 975702;
            28: return 985278;  29: return 992480;  30: return 997290;  default: return 999699;
        endcase
    endfunction

    function automatic int unsigned lut_entry(input int unsigned dw, input int unsigned j);
        longint unsigned amp;
        amp = (longint'(1) << (dw - 1)) - 1;
        return int'((amp * longint'(sin_ppm(j)) + 64'd500000) / 64'd1000000);
    endfunction

    function automatic logic signed [31:0] sat_neg(input logic signed [31:0] v,
                                                   input int unsigned w);
        logic signed [31:0] lo;
        lo = -(32'sd1 <<< (w - 1));
        if (v == lo)
            return (32'sd1 <<< (w - 1)) - 32'sd1;
        return -v;
    endfunction

    function automatic refl_t reflect(input logic signed [31:0] n,
                                      input logic signed [31:0] lim);
        if (n < 0)
            return {1'b1, 32'(-n)};
        if (n >= lim)
            return {1'b1, 32'(2 * lim - n)};
        return {1'b0, 32'(n)};
    endfunction

endpackage

// File: rtl/kinematics_multi_lut.sv
// Combinational quarter-wave sine magnitude table, 32 entries.
module quarter_sine_lut
    import kinematics_pkg::*;
#(
    parameter int DW = 6
) (
    input  logic [4:0]    idx,
    output logic [DW-2:0] mag
);

    localparam int MW = DW - 1;

    logic [MW-1:0] tbl [32];

    for (genvar j = 0; j < 32; j++) begin : g_tbl
        assign tbl[j] = MW'(lut_entry(DW, j));
    end

    assign mag = tbl[idx];

endmodule

// File: rtl/kinematics_multi.sv
// Multi-object kinematics: per-frame integration, wall reflection, axis offsets
// and their products, processed one object at a time into a readable result file.
module kinematics_multi
    import kinematics_pkg::*;
#(
    parameter int N_OBJ  = 4,
    parameter int POS_W  = 10,
    parameter int FRAC_W = 2,
    parameter int VEL_W  = 6,
    parameter int PHI_W  = 11,
    parameter int DW     = 6,
    parameter int X_LIM  = 640,
    parameter int Y_LIM  = 480,
    localparam int KW    = (N_OBJ > 1) ? $clog2(N_OBJ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [KW-1:0]        load_idx,
    input  logic [POS_W-1:0]     init_x,
    input  logic [POS_W-1:0]     init_y,
    input  logic [6:0]           init_phi,
    input  logic [VEL_W-1:0]     init_vx,
    input  logic [VEL_W-1:0]     init_vy,
    input  logic [VEL_W-1:0]     init_w,
    input  logic                 update,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun,
    input  logic [KW-1:0]        rd_idx,
    output logic [POS_W-1:0]     center_x,
    output logic [POS_W-1:0]     center_y,
    output logic [2:0]           phi_hi,
    output logic signed [DW-1:0] dx,
    output logic signed [DW-1:0] dy,
    output logic [2*DW-1:0]      dx_s,
    output logic [2*DW-1:0]      dy_s,
    output logic signed [2*DW-1:0] dx_dy,
    output logic [1:0]           bounced
);

    localparam int PW = POS_W + FRAC_W;
    localparam int MW = DW - 1;
    localparam int CW = $clog2(DW + 1);
    localparam logic signed [31:0] LX = 32'(X_LIM << FRAC_W);
    localparam logic signed [31:0] LY = 32'(Y_LIM << FRAC_W);

    state_t state, state_n;

    logic [PW-1:0]    px  [N_OBJ];
    logic [PW-1:0]    py  [N_OBJ];
    logic [VEL_W-1:0] vx  [N_OBJ];
    logic [VEL_W-1:0] vy  [N_OBJ];
    logic [VEL_W-1:0] w   [N_OBJ];
    logic [PHI_W-1:0] phi [N_OBJ];

    logic [POS_W-1:0] res_cx   [N_OBJ];
    logic [POS_W-1:0] res_cy   [N_OBJ];
    logic [2:0]       res_ph   [N_OBJ];
    logic [DW-1:0]    res_dx   [N_OBJ];
    logic [DW-1:0]    res_dy   [N_OBJ];
    logic [2*DW-1:0]  res_dxs  [N_OBJ];
    logic [2*DW-1:0]  res_dys  [N_OBJ];
    logic [2*DW-1:0]  res_dxdy [N_OBJ];
    logic [1:0]       res_bn   [N_OBJ];

    logic [KW-1:0]   k;
    logic [CW-1:0]   cnt;
    logic [1:0]      bnc_r;
    logic            neg_x, neg_y;
    logic [DW-1:0]   mag_x, mag_y, mp_x, mp_y;
    logic [2*DW-1:0] mc_x, mc_y, acc_xx, acc_yy, acc_xy;

    logic            last, drop;
    logic [1:0]      quad;
    logic [4:0]      fine, sin_idx, cos_idx;
    logic [MW-1:0]   sin_mag, cos_mag;
    logic signed [31:0] nx, ny;
    logic [PW-1:0]   rx_pos, ry_pos;
    logic            rx_b, ry_b;

    quarter_sine_lut #(.DW(DW)) u_sin (.idx(sin_idx), .mag(sin_mag));
    quarter_sine_lut #(.DW(DW)) u_cos (.idx(cos_idx), .mag(cos_mag));

    always_ff @(posedge clk) begin
        if (rst)
            state <= MOVE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        busy    = (state != IDLE);
        last    = (k == KW'(N_OBJ - 1));
        // load wins over a same-cycle update; anything arriving mid-pass is dropped
        drop    = (state != IDLE) ? (update || load) : (update && load);
        case (state)
            IDLE:  if (update && !load) state_n = MOVE;
            MOVE:  state_n = TRIG;
            TRIG:  state_n = MUL;
            MUL:   if (cnt == CW'(DW - 1)) state_n = STORE;
            STORE: state_n = last ? IDLE : MOVE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        quad    = phi[k][PHI_W-1 -: 2];
        fine    = phi[k][PHI_W-3 -: 5];
        sin_idx = quad[0] ? ~fine : fine;
        cos_idx = quad[0] ? fine : ~fine;
        nx      = signed'(32'(px[k])) + 32'(signed'(vx[k]));
        ny      = signed'(32'(py[k])) + 32'(signed'(vy[k]));
        rx_pos  = PW'(reflect(nx, LX));
        ry_pos  = PW'(reflect(ny, LY));
        rx_b    = 1'(reflect(nx, LX) >> 32);
        ry_b    = 1'(reflect(ny, LY) >> 32);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_OBJ; i++) begin
                px[i]       <= '0;
                py[i]       <= '0;
                vx[i]       <= '0;
                vy[i]       <= '0;
                w[i]        <= '0;
                phi[i]      <= '0;
                res_cx[i]   <= '0;
                res_cy[i]   <= '0;
                res_ph[i]   <= '0;
                res_dx[i]   <= '0;
                res_dy[i]   <= '0;
                res_dxs[i]  <= '0;
                res_dys[i]  <= '0;
                res_dxdy[i] <= '0;
                res_bn[i]   <= '0;
            end
            k       <= '0;
            cnt     <= '0;
            bnc_r   <= '0;
            neg_x   <= 1'b0;
            neg_y   <= 1'b0;
            mag_x   <= '0;
            mag_y   <= '0;
            mp_x    <= '0;
            mp_y    <= '0;
            mc_x    <= '0;
            mc_y    <= '0;
            acc_xx  <= '0;
            acc_yy  <= '0;
            acc_xy  <= '0;
            done    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            done    <= (state == STORE) && last;
            overrun <= drop;
            case (state)
                IDLE: begin
                    if (load) begin
                        px[load_idx]  <= {init_x, FRAC_W'(0)};
                        py[load_idx]  <= {init_y, FRAC_W'(0)};
                        vx[load_idx]  <= init_vx;
                        vy[load_idx]  <= init_vy;
                        w[load_idx]   <= init_w;
                        phi[load_idx] <= {init_phi, (PHI_W - 7)'(0)};
                    end else if (update) begin
                        k <= '0;
                    end
                end
                MOVE: begin
                    px[k]  <= rx_pos;
                    py[k]  <= ry_pos;
                    if (rx_b) vx[k] <= VEL_W'(sat_neg(32'(signed'(vx[k])), VEL_W));
                    if (ry_b) vy[k] <= VEL_W'(sat_neg(32'(signed'(vy[k])), VEL_W));
                    phi[k] <= phi[k] + PHI_W'(signed'(w[k]));
                    bnc_r  <= {ry_b, rx_b};
                end
                TRIG: begin
                    mag_x  <= DW'(cos_mag);
                    mag_y  <= DW'(sin_mag);
                    mp_x   <= DW'(cos_mag);
                    mp_y   <= DW'(sin_mag);
                    mc_x   <= (2*DW)'(cos_mag);
                    mc_y   <= (2*DW)'(sin_mag);
                    acc_xx <= '0;
                    acc_yy <= '0;
                    acc_xy <= '0;
                    neg_x  <= (quad == 2'd1) || (quad == 2'd2);
                    neg_y  <= quad[1];
                    cnt    <= '0;
                end
                MUL: begin
                    acc_xx <= acc_xx + (mp_x[0] ? mc_x : '0);
                    acc_yy <= acc_yy + (mp_y[0] ? mc_y : '0);
                    acc_xy <= acc_xy + (mp_y[0] ? mc_x : '0);
                    mc_x   <= mc_x << 1;
                    mc_y   <= mc_y << 1;
                    mp_x   <= mp_x >> 1;
                    mp_y   <= mp_y >> 1;
                    cnt    <= cnt + CW'(1);
                end
                STORE: begin
                    res_cx[k]   <= px[k][PW-1:FRAC_W];
                    res_cy[k]   <= py[k][PW-1:FRAC_W];
                    res_ph[k]   <= phi[k][PHI_W-1 -: 3];
                    res_dx[k]   <= neg_x ? -mag_x : mag_x;
                    res_dy[k]   <= neg_y ? -mag_y : mag_y;
                    res_dxs[k]  <= acc_xx;
                    res_dys[k]  <= acc_yy;
                    res_dxdy[k] <= (neg_x ^ neg_y) ? -acc_xy : acc_xy;
                    res_bn[k]   <= bnc_r;
                    if (!last) k <= k + KW'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            center_x <= '0;
            center_y <= '0;
            phi_hi   <= '0;
            dx       <= '0;
            dy       <= '0;
            dx_s     <= '0;
            dy_s     <= '0;
            dx_dy    <= '0;
            bounced  <= '0;
        end else begin
            center_x <= res_cx[rd_idx];
            center_y <= res_cy[rd_idx];
            phi_hi   <= res_ph[rd_idx];
            dx       <= res_dx[rd_idx];
            dy       <= res_dy[rd_idx];
            dx_s     <= res_dxs[rd_idx];
            dy_s     <= res_dys[rd_idx];
            dx_dy    <= res_dxdy[rd_idx];
            bounced  <= res_bn[rd_idx];
        end
    end

endmodule

// File: tb/tb_kinematics_multi.sv
// Directed bench for kinematics_multi: result tables per pass plus timing corner sequences.
module tb_kinematics_multi;

    logic        clk = 1'b0;
    logic        rst, load, update;
    logic [1:0]  load_idx, rd_idx;
    logic [9:0]  init_x, init_y;
    logic [6:0]  init_phi;
    logic [5:0]  init_vx, init_vy, init_w;
    logic        busy, done, overrun;
    logic [9:0]  center_x, center_y;
    logic [2:0]  phi_hi;
    logic [5:0]  dx, dy;
    logic [11:0] dx_s, dy_s, dx_dy;
    logic [1:0]  bounced;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    kinematics_multi #(.N_OBJ(4), .POS_W(10), .FRAC_W(2), .VEL_W(6), .PHI_W(11),
                       .DW(6), .X_LIM(640), .Y_LIM(480)) dut (
        .clk(clk), .rst(rst), .load(load), .load_idx(load_idx),
        .init_x(init_x), .init_y(init_y), .init_phi(init_phi),
        .init_vx(init_vx), .init_vy(init_vy), .init_w(init_w),
        .update(update), .busy(busy), .done(done), .overrun(overrun),
        .rd_idx(rd_idx), .center_x(center_x), .center_y(center_y), .phi_hi(phi_hi),
        .dx(dx), .dy(dy), .dx_s(dx_s), .dy_s(dy_s), .dx_dy(dx_dy), .bounced(bounced)
    );

    typedef struct {
        int          idx;
        logic [9:0]  cx, cy;
        logic [2:0]  ph;
        logic [5:0]  dx, dy;
        logic [11:0] dxs, dys, dxdy;
        logic [1:0]  bn;
    } exp_t;

    exp_t tab [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic read_check(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            rd_idx = 2'(tab[i].idx);
            @(negedge clk);
            chk($sformatf("v%0d center_x", i), 32'(center_x), 32'(tab[i].cx));
            chk($sformatf("v%0d center_y", i), 32'(center_y), 32'(tab[i].cy));
            chk($sformatf("v%0d phi_hi", i),   32'(phi_hi),   32'(tab[i].ph));
            chk($sformatf("v%0d dx", i),       32'(dx),       32'(tab[i].dx));
            chk($sformatf("v%0d dy", i),       32'(dy),       32'(tab[i].dy));
            chk($sformatf("v%0d dx_s", i),     32'(dx_s),     32'(tab[i].dxs));
            chk($sformatf("v%0d dy_s", i),     32'(dy_s),     32'(tab[i].dys));
            chk($sformatf("v%0d dx_dy", i),    32'(dx_dy),    32'(tab[i].dxdy));
            chk($sformatf("v%0d bounced", i),  32'(bounced),  32'(tab[i].bn));
        end
    endtask

    // Counts negedges until done; optionally pulses update at cycle pulse_at.
    task automatic wait_done(input int pulse_at, output int cycles, output int ovs);
        cycles = 0;
        ovs    = 0;
        while (cycles < 200) begin
            @(negedge clk);
            cycles++;
            if (overrun) ovs++;
            update = (cycles == pulse_at);
            if (done) break;
        end
        update = 1'b0;
    endtask

    task automatic start_pass(input int pulse_at, output int cycles, output int ovs);
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        chk("busy after update", 32'(busy), 32'd1);
        wait_done(pulse_at, cycles, ovs);
    endtask

    task automatic do_load(input int idx, input int x, input int y, input int ph,
                           input int vxi, input int vyi, input int wi, input logic with_upd);
        load     = 1'b1;
        update   = with_upd;
        load_idx = 2'(idx);
        init_x   = 10'(x);
        init_y   = 10'(y);
        init_phi = 7'(ph);
        init_vx  = 6'(vxi);
        init_vy  = 6'(vyi);
        init_w   = 6'(wi);
        @(negedge clk);
        load   = 1'b0;
        update = 1'b0;
        chk($sformatf("busy after load %0d", idx), 32'(busy), 32'd0);
    endtask

    function automatic exp_t mk(int idx, int cx, int cy, int ph, int dxv, int dyv,
                                int dxs, int dys, int dxdy, int bn);
        exp_t e;
        e.idx = idx;  e.cx = 10'(cx); e.cy = 10'(cy); e.ph = 3'(ph);
        e.dx = 6'(dxv); e.dy = 6'(dyv); e.dxs = 12'(dxs); e.dys = 12'(dys);
        e.dxdy = 12'(dxdy); e.bn = 2'(bn);
        return e;
    endfunction

    initial begin
        int cyc, ovs;

        // reset defaults: phi=0 gives cos=31, sin=1 for every object
        for (int i = 0; i < 4; i++) begin
            tab[i]      = mk(i, 0, 0, 0, 31, 1, 961, 1, 31, 0);
            tab[12 + i] = mk(i, 0, 0, 0, 31, 1, 961, 1, 31, 0);
        end
        tab[4]  = mk(0, 100, 100, 2, -1, 31, 1, 961, -31, 0);
        tab[5]  = mk(1, 633, 0,   0, 31, 1, 961, 1, 31, 1);
        tab[6]  = mk(2, 1,   479, 0, 31, 1, 961, 1, 31, 3);
        tab[7]  = mk(3, 8,   0,   7, 31, -1, 961, 1, -31, 1);
        tab[8]  = mk(0, 100, 100, 2, -1, 31, 1, 961, -31, 0);
        tab[9]  = mk(1, 625, 0,   0, 31, 1, 961, 1, 31, 0);
        tab[10] = mk(2, 2,   477, 0, 31, 1, 961, 1, 31, 0);
        tab[11] = mk(3, 15,  0,   7, 31, -1, 961, 1, -31, 0);

        rst = 1'b1; load = 1'b0; update = 1'b0; load_idx = '0; rd_idx = '0;
        init_x = '0; init_y = '0; init_phi = '0; init_vx = '0; init_vy = '0; init_w = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("busy first cycle after reset", 32'(busy), 32'd1);
        chk("done after reset", 32'(done), 32'd0);
        chk("dx read before first store", 32'(dx), 32'd0);
        wait_done(-1, cyc, ovs);
        chk("reset pass length", 32'(cyc), 32'd36);
        chk("busy low with done", 32'(busy), 32'd0);
        chk("no overrun in reset pass", 32'(ovs), 32'd0);
        @(negedge clk);
        chk("done is one cycle", 32'(done), 32'd0);
        read_check(0, 3);

        do_load(1, 639, 0, 0, 31, 0, 0, 1'b0);
        do_load(2, 0, 479, 0, -4, 8, 0, 1'b0);
        do_load(3, 0, 0, 0, -32, 0, -1, 1'b0);
        do_load(0, 100, 100, 7'h20, 0, 0, 0, 1'b1);
        chk("overrun on load+update", 32'(overrun), 32'd1);
        @(negedge clk);
        chk("overrun one cycle", 32'(overrun), 32'd0);
        chk("still idle after load+update", 32'(busy), 32'd0);
        read_check(1, 1);  // loaded object keeps stale results until next pass

        start_pass(-1, cyc, ovs);
        chk("pass B length", 32'(cyc), 32'd36);
        read_check(4, 7);

        start_pass(5, cyc, ovs);
        chk("pass C length with dropped update", 32'(cyc), 32'd36);
        chk("pass C overrun pulses", 32'(ovs), 32'd1);
        @(negedge clk);
        chk("no restart after overrun", 32'(busy), 32'd0);
        read_check(8, 11);

        // abort a pass with reset at cycle 10
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        repeat (9) @(negedge clk);
        chk("busy mid pass", 32'(busy), 32'd1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("done cleared by reset", 32'(done), 32'd0);
        chk("overrun cleared by reset", 32'(overrun), 32'd0);
        chk("center_x cleared by reset", 32'(center_x), 32'd0);
        rst = 1'b0;
        #1;
        chk("busy after mid-pass reset", 32'(busy), 32'd1);
        wait_done(-1, cyc, ovs);
        chk("pass after abort length", 32'(cyc), 32'd36);
        read_check(12, 15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
